wb_cmd_master: RTL and testbench

//  Wishbone classic initiator: converts a valid/ready command stream into single WB cycles

---
 rtl/wb_cmd_master_pkg.sv | 22 ++
 rtl/wb_cmd_master_tmo_counter.sv | 30 +++
 rtl/wb_cmd_master.sv | 133 +++++++++++++
 tb/tb_wb_cmd_master.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_cmd_master_pkg.sv
// Shared Wishbone definitions for the command master: bus widths, FSM
// state encodings and the user-project slave decode bases.
package wb_cmd_master_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    // Slave decode: user memory lives at 0x38xx_xxxx (adr[31:24]).
    localparam logic [7:0]  USER_MEM_BASE = 8'h38;
    localparam logic [31:0] UART_BASE     = 32'h3000_0000;

    function automatic logic is_user_mem(input logic [31:0] adr);
        return adr[31:24] == USER_MEM_BASE;
    endfunction

endpackage

// File: rtl/wb_cmd_master_tmo_counter.sv
// Ack-timeout counter: cleared when a cycle starts, counts bus cycles while
// enabled, saturates, and flags the last permitted cycle. TIMEOUT=0 never expires.
module wb_cmd_master_tmo_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] MAX  = '1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != MAX)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Expires on the edge that ends the TIMEOUT-th cycle with cyc high.
    assign o_expired = (TIMEOUT != 0) && i_enable && (r_cnt == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one command in, one single WB cycle out, one
// response back. A missing ack turns into an error response after TIMEOUT cycles.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int DATA_W  = WB_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_W-1:0]     cmd_adr,
    input  logic [DATA_W-1:0]     cmd_dat,
    input  logic [DATA_W/8-1:0]   cmd_sel,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_dat,
    output logic                  rsp_err,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [DATA_W/8-1:0]   wbm_sel_o,
    output logic [ADDR_W-1:0]     wbm_adr_o,
    output logic [DATA_W-1:0]     wbm_dat_o,
    input  logic                  wbm_ack_i,
    input  logic [DATA_W-1:0]     wbm_dat_i,
    output logic [1:0]            o_dbg_state
);

    // Handshakes: a transfer happens on an edge where valid && ready are both
    // high; valid never depends on ready and payload is stable while valid is high.

    wb_state_e             r_state;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_dat;
    logic                  r_rsp_err;
    logic                  r_cyc;
    logic                  r_we;
    logic [DATA_W/8-1:0]   r_sel;
    logic [ADDR_W-1:0]     r_adr;
    logic [DATA_W-1:0]     r_dat;

    logic w_accept;
    logic w_in_bus;
    logic w_expired;

    assign w_accept = (r_state == ST_IDLE) && r_cmd_ready && cmd_valid;
    assign w_in_bus = (r_state == ST_BUS);

    wb_cmd_master_tmo_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .i_clk     (wb_clk_i),
        .i_rst     (wb_rst_i),
        .i_clear   (w_accept),
        .i_enable  (w_in_bus),
        .o_expired (w_expired)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we        <= cmd_we;
                        r_adr       <= cmd_adr;
                        r_dat       <= cmd_dat;
                        r_sel       <= cmd_sel;
                        r_cyc       <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_BUS;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                ST_BUS: begin
                    // Ack takes priority over a timeout landing on the same edge.
                    if (wbm_ack_i) begin
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= r_we ? '0 : wbm_dat_i;
                        r_rsp_err   <= 1'b0;
                        r_state     <= ST_RESP;
                    end else if (w_expired) begin
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_dat     = r_rsp_dat;
    assign rsp_err     = r_rsp_err;
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = r_we;
    assign wbm_sel_o   = r_sel;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: scripted Wishbone slave with programmable wait
// states, response scoreboard, and one task per scenario.
module tb_wb_cmd_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;

    logic          wb_clk_i;
    logic          wb_rst_i;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [SW-1:0] cmd_sel;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;
    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic          wbm_we_o;
    logic [SW-1:0] wbm_sel_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o;
    logic          wbm_ack_i;
    logic [DW-1:0] wbm_dat_i;
    logic [1:0]    o_dbg_state;

    wb_cmd_master #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_adr     (cmd_adr),
        .cmd_dat     (cmd_dat),
        .cmd_sel     (cmd_sel),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_dat     (rsp_dat),
        .rsp_err     (rsp_err),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_dat_i   (wbm_dat_i),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [DW:0] exp_q[$];   // {err, dat}
    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- slave model ----------------
    int          slv_wait  = 0;   // wait states before ack; -1 = never ack
    bit          slv_fixed = 1'b0;
    logic [DW-1:0] slv_rdata = '0;
    int          slv_cnt   = 0;
    logic        slv_ack   = 1'b0;
    logic        spur_ack  = 1'b0;

    function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    always @(negedge wb_clk_i) begin
        if (wbm_cyc_o) begin
            slv_ack = (slv_wait >= 0) && (slv_cnt == slv_wait);
            slv_cnt = slv_cnt + 1;
        end else begin
            slv_ack = 1'b0;
            slv_cnt = 0;
        end
        wbm_dat_i = slv_ack ? (slv_fixed ? slv_rdata : rd_fn(wbm_adr_o)) : 32'hBAD0_0000;
    end

    assign wbm_ack_i = slv_ack | spur_ack;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Offers a command, waits for acceptance, then follows the bus cycle until
    // rsp_valid rises. n_lat counts cycles from the accept edge (-1 = none).
    task automatic issue(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel, output int n_cyc, output int n_lat,
                         output bit vals_ok);
        int guard;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        cmd_valid = 1'b0;
        n_cyc   = 0;
        n_lat   = 1;
        vals_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (wbm_cyc_o) begin
                n_cyc++;
                if (wbm_stb_o !== 1'b1 || wbm_we_o !== we || wbm_adr_o !== adr ||
                    wbm_dat_o !== dat || wbm_sel_o !== sel)
                    vals_ok = 1'b0;
            end
            if (rsp_valid) break;
            tick();
            n_lat++;
        end
        if (!rsp_valid) n_lat = -1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        wb_rst_i = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({cmd_ready, rsp_valid, wbm_cyc_o, wbm_stb_o, rsp_err} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got rdy=%b rv=%b cyc=%b stb=%b err=%b, want all 0",
                     cmd_ready, rsp_valid, wbm_cyc_o, wbm_stb_o, rsp_err);
        end
        n_cmp++;
        if (wbm_adr_o !== '0 || wbm_dat_o !== '0 || wbm_sel_o !== '0 || wbm_we_o !== 1'b0 ||
            rsp_dat !== '0 || o_dbg_state !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_data: adr=%h dat=%h sel=%h we=%b rdat=%h st=%0d, want all 0",
                     wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, rsp_dat, o_dbg_state);
        end
        wb_rst_i = 1'b0;
        tick();
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        int nc, nl;
        bit ok;
        logic [DW:0] e;
        slv_wait = 2;
        exp_q.push_back({1'b0, 32'h0});
        issue(1'b1, 32'h3800_0010, 32'hA5A5_0001, 4'hF, nc, nl, ok);
        n_cmp++;
        if (nc !== 3 || !ok) begin
            n_bad++;
            $display("FAIL write_bus: cyc cycles=%0d vals_ok=%0d, want 3 and 1", nc, ok);
        end
        n_cmp++;
        if (nl !== 4) begin
            n_bad++;
            $display("FAIL write_latency: got %0d want 4", nl);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({rsp_err, rsp_dat} !== e) begin
            n_bad++;
            $display("FAIL write_rsp: got err=%b dat=%h want err=%b dat=%h", rsp_err, rsp_dat, e[DW], e[DW-1:0]);
        end
        consume();
        n_cmp++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL write_consume: rv=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_read();
        int nc, nl;
        bit ok;
        logic [DW:0] e;
        slv_wait  = 0;
        slv_fixed = 1'b1;
        slv_rdata = 32'h1234_5678;
        exp_q.push_back({1'b0, 32'h1234_5678});
        issue(1'b0, 32'h3800_0020, $urandom, 4'h3, nc, nl, ok);
        n_cmp++;
        if (nl !== 2 || nc !== 1 || !ok) begin
            n_bad++;
            $display("FAIL read_timing: lat=%0d cyc=%0d ok=%0d want 2 1 1", nl, nc, ok);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({rsp_err, rsp_dat} !== e) begin
            n_bad++;
            $display("FAIL read_rsp: got err=%b dat=%h want err=%b dat=%h", rsp_err, rsp_dat, e[DW], e[DW-1:0]);
        end
        consume();
        slv_fixed = 1'b0;
    endtask

    task automatic test_timeout();
        int nc, nl;
        bit ok;
        logic [DW:0] e;
        slv_wait = -1;
        exp_q.push_back({1'b1, 32'h0});
        issue(1'b0, 32'h3800_0040, 32'h0, 4'hF, nc, nl, ok);
        n_cmp++;
        if (nc !== TMO || nl !== TMO + 1 || !ok) begin
            n_bad++;
            $display("FAIL timeout_bus: cyc=%0d lat=%0d ok=%0d want %0d %0d 1", nc, nl, ok, TMO, TMO + 1);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({rsp_err, rsp_dat} !== e) begin
            n_bad++;
            $display("FAIL timeout_rsp: got err=%b dat=%h want err=%b dat=%h", rsp_err, rsp_dat, e[DW], e[DW-1:0]);
        end
        consume();
        slv_wait = 1;
        exp_q.push_back({1'b0, rd_fn(32'h3000_0004)});
        issue(1'b0, 32'h3000_0004, 32'h0, 4'hF, nc, nl, ok);
        n_cmp++;
        if (nc !== 2 || nl !== 3 || !ok) begin
            n_bad++;
            $display("FAIL after_timeout_bus: cyc=%0d lat=%0d ok=%0d want 2 3 1", nc, nl, ok);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({rsp_err, rsp_dat} !== e) begin
            n_bad++;
            $display("FAIL after_timeout_rsp: got err=%b dat=%h want err=%b dat=%h", rsp_err, rsp_dat, e[DW], e[DW-1:0]);
        end
        consume();
    endtask

    task automatic test_rsp_stall();
        int nc, nl;
        bit ok, stable;
        logic [DW:0] e;
        logic [AW-1:0] a1, a2;
        logic [DW-1:0] d2;
        slv_wait = 0;
        a1 = {8'h38, 16'($urandom), 8'h00};
        a2 = {8'h38, 16'($urandom), 8'h04};
        d2 = $urandom;
        exp_q.push_back({1'b0, rd_fn(a1)});
        issue(1'b0, a1, 32'h0, 4'hF, nc, nl, ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (nl !== 2 || {rsp_err, rsp_dat} !== e) begin
            n_bad++;
            $display("FAIL stall_rsp: lat=%0d err=%b dat=%h want 2 err=%b dat=%h", nl, rsp_err, rsp_dat, e[DW], e[DW-1:0]);
        end
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = a2;
        cmd_dat   = d2;
        cmd_sel   = 4'h5;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || {rsp_err, rsp_dat} !== e || cmd_ready !== 1'b0 ||
                wbm_cyc_o !== 1'b0 || o_dbg_state !== 2'd2)
                stable = 1'b0;
        end
        n_cmp++;
        if (!stable) begin
            n_bad++;
            $display("FAIL stall_hold: rv=%b dat=%h rdy=%b cyc=%b st=%0d, want 1 %h 0 0 2",
                     rsp_valid, rsp_dat, cmd_ready, wbm_cyc_o, o_dbg_state, e[DW-1:0]);
        end
        consume();
        n_cmp++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_release: rdy=%b rv=%b cyc=%b want 1 0 0", cmd_ready, rsp_valid, wbm_cyc_o);
        end
        exp_q.push_back({1'b0, 32'h0});
        issue(1'b1, a2, d2, 4'h5, nc, nl, ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (nl !== 2 || !ok || {rsp_err, rsp_dat} !== e) begin
            n_bad++;
            $display("FAIL stall_next_cmd: lat=%0d ok=%0d err=%b dat=%h want 2 1 err=%b dat=%h",
                     nl, ok, rsp_err, rsp_dat, e[DW], e[DW-1:0]);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int idx, nrsp, last_acc;
        bit acc, spacing_ok;
        logic [DW:0] e;
        logic [AW-1:0] a;
        slv_wait   = 0;
        rsp_ready  = 1'b1;
        idx        = 0;
        nrsp       = 0;
        last_acc   = -1;
        spacing_ok = 1'b1;
        a = 32'h3800_0100;
        cmd_valid = 1'b1;
        cmd_we = 1'b0; cmd_adr = a; cmd_dat = $urandom; cmd_sel = 4'hF;
        for (int c = 0; c < 60 && nrsp < 4; c++) begin
            acc = cmd_valid && cmd_ready;
            if (rsp_valid) begin
                nrsp++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_rsp: unexpected response err=%b dat=%h", rsp_err, rsp_dat);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_err, rsp_dat} !== e) begin
                        n_bad++;
                        $display("FAIL b2b_rsp: got err=%b dat=%h want err=%b dat=%h",
                                 rsp_err, rsp_dat, e[DW], e[DW-1:0]);
                    end
                end
            end
            if (acc) begin
                if (last_acc >= 0 && c - last_acc != 3) spacing_ok = 1'b0;
                last_acc = c;
                exp_q.push_back({1'b0, cmd_we ? 32'h0 : rd_fn(cmd_adr)});
            end
            tick();
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    cmd_we  = idx[0];
                    cmd_adr = a + 32'(idx * 4);
                    cmd_dat = $urandom;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        rsp_ready = 1'b0;
        n_cmp++;
        if (nrsp !== 4 || !spacing_ok) begin
            n_bad++;
            $display("FAIL b2b_spacing: responses=%0d spacing_ok=%0d want 4 1", nrsp, spacing_ok);
        end
    endtask

    task automatic test_reset_in_bus();
        bit quiet;
        slv_wait  = -1;
        cmd_valid = 1'b1;
        cmd_we = 1'b1; cmd_adr = 32'h3800_0200; cmd_dat = 32'h55AA_55AA; cmd_sel = 4'hF;
        tick();
        cmd_valid = 1'b0;
        tick();
        n_cmp++;
        if (wbm_cyc_o !== 1'b1 || o_dbg_state !== 2'd1) begin
            n_bad++;
            $display("FAIL rst_bus_setup: cyc=%b st=%0d want 1 1", wbm_cyc_o, o_dbg_state);
        end
        wb_rst_i = 1'b1;
        tick();
        n_cmp++;
        if ({wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready} !== 4'b0) begin
            n_bad++;
            $display("FAIL rst_bus_drop: cyc=%b stb=%b rv=%b rdy=%b want 0 0 0 0",
                     wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready);
        end
        wb_rst_i = 1'b0;
        tick();
        quiet = (cmd_ready === 1'b1);
        for (int i = 0; i < TMO + 4; i++) begin
            if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) quiet = 1'b0;
            tick();
        end
        n_cmp++;
        if (!quiet) begin
            n_bad++;
            $display("FAIL rst_bus_after: rdy=%b rv=%b cyc=%b want 1 0 0", cmd_ready, rsp_valid, wbm_cyc_o);
        end
    endtask

    task automatic test_spurious_ack();
        int nc, nl;
        bit ok, idle_ok, resp_ok;
        logic [DW:0] e;
        spur_ack = 1'b1;
        idle_ok  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (o_dbg_state !== 2'd0 || rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || cmd_ready !== 1'b1)
                idle_ok = 1'b0;
        end
        spur_ack = 1'b0;
        n_cmp++;
        if (!idle_ok) begin
            n_bad++;
            $display("FAIL spur_idle: st=%0d rv=%b cyc=%b rdy=%b want 0 0 0 1", o_dbg_state, rsp_valid, wbm_cyc_o, cmd_ready);
        end
        slv_wait = 0;
        exp_q.push_back({1'b0, rd_fn(32'h3800_0300)});
        issue(1'b0, 32'h3800_0300, 32'h0, 4'hF, nc, nl, ok);
        e = exp_q.pop_front();
        spur_ack = 1'b1;
        resp_ok  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || o_dbg_state !== 2'd2 || {rsp_err, rsp_dat} !== e) resp_ok = 1'b0;
        end
        spur_ack = 1'b0;
        n_cmp++;
        if (!resp_ok) begin
            n_bad++;
            $display("FAIL spur_resp: rv=%b st=%0d err=%b dat=%h want 1 2 err=%b dat=%h",
                     rsp_valid, o_dbg_state, rsp_err, rsp_dat, e[DW], e[DW-1:0]);
        end
        consume();
        resp_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid !== 1'b0 || o_dbg_state !== 2'd0) resp_ok = 1'b0;
            tick();
        end
        n_cmp++;
        if (!resp_ok) begin
            n_bad++;
            $display("FAIL spur_extra_rsp: rv=%b st=%0d want 0 0", rsp_valid, o_dbg_state);
        end
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        wb_rst_i  = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_rsp_stall();
        test_back_to_back();
        test_reset_in_bus();
        test_spurious_ack();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
